// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
// Time-multiplexing controller for a 4-digit FND. It divides the system clock
// down to a per-digit scan period of DIV = CLK_FREQ/SCAN_FREQ clocks. It steps
// through the digits enabled in i_digitMask. It blanks the display for
// BLANK_CYCLES clocks at the start of every digit period to suppress ghosting.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous, active-low reset
//   i_run          1 = scanning, 0 = display off
//   i_digitMask    bit n = 1 shows digit n, 0 bits are skipped
//   o_digitSelect  current digit index (to downstream i_digitSelect)
//   o_en           0 = digit displayed, 1 = all digits blanked (to downstream i_en)
//   o_scanTick     one-clock pulse in the cycle o_digitSelect is (re)loaded
//
// Handshake: there is none. The inputs are level signals sampled on every rising
// edge. All outputs are registered and are valid in every cycle.
//
// BLANK_CYCLES must be smaller than DIV, so the prescaler tick always falls in
// SHOW.

module fnd_scan_ctrl #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int SCAN_FREQ    = 1_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_run,
  input  logic [3:0] i_digitMask,
  output logic [1:0] o_digitSelect,
  output logic       o_en,
  output logic       o_scanTick
);

  localparam int DIV   = CLK_FREQ / SCAN_FREQ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  // The +2 keeps the width at 1 bit or more, even when BLANK_CYCLES is 0.
  localparam int BLK_W = $clog2(BLANK_CYCLES + 2);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'(BLANK_CYCLES);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // With no blanking window, a digit change lands directly in SHOW.
  localparam state_t SCAN_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [BLK_W-1:0]   blank_cnt;
  logic [BLK_W-1:0]   blank_nxt;
  logic [1:0]         sel_nxt;
  logic               en_nxt;
  logic               tick_nxt;
  logic               stop;

  // First set mask bit, searching d+1, d+2, d+3 and then d itself (mod 4).
  // The loop runs from the far end back toward d+1, so the nearest hit wins.
  // Called with d = 3, the search order is 0,1,2,3.
  function automatic logic [1:0] next_digit(input logic [1:0] d,
                                            input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] c;
    r = d;
    for (int k = 3; k >= 1; k--) begin
      c = d + 2'(k);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  assign stop    = !i_run || (i_digitMask == 4'b0000);
  assign cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      blank_cnt     <= '0;
      o_digitSelect <= 2'd0;
      o_en          <= 1'b1;
      o_scanTick    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      blank_cnt     <= blank_nxt;
      o_digitSelect <= sel_nxt;
      o_en          <= en_nxt;
      o_scanTick    <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    blank_nxt = blank_cnt;
    sel_nxt   = o_digitSelect;
    tick_nxt  = 1'b0;

    if (stop) begin
      // Stopping has priority in every state. The digit index is held.
      state_nxt = IDLE;
      cnt_nxt   = '0;
      blank_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SCAN_START;
          sel_nxt   = next_digit(2'd3, i_digitMask);
          tick_nxt  = 1'b1;
          cnt_nxt   = '0;
          blank_nxt = BLK_INIT;
        end
        BLANK: begin
          cnt_nxt   = cnt_inc;
          blank_nxt = blank_cnt - BLK_ONE;
          // The counter is loaded with BLANK_CYCLES and leaves BLANK at 1.
          // This gives exactly BLANK_CYCLES blanked clocks.
          if (blank_cnt == BLK_ONE) state_nxt = SHOW;
        end
        SHOW: begin
          cnt_nxt = cnt_inc;
          if (cnt == CNT_LAST) begin
            // The mask is sampled here, so a mask change only takes effect
            // at a digit boundary.
            sel_nxt   = next_digit(o_digitSelect, i_digitMask);
            tick_nxt  = 1'b1;
            state_nxt = SCAN_START;
            blank_nxt = BLK_INIT;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          blank_nxt = '0;
        end
      endcase
    end

    en_nxt = (state_nxt != SHOW);
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Testbench for fnd_scan_ctrl with DIV = 10 and BLANK_CYCLES = 2.
// The reference model tracks three things: whether the display is running,
// the current digit, and the position inside the 10-clock digit period.
// o_en is derived from that position.

module tb_fnd_scan_ctrl;

  localparam int CLK_FREQ  = 100;
  localparam int SCAN_FREQ = 10;
  localparam int BLANK     = 2;
  localparam int DIV       = CLK_FREQ / SCAN_FREQ;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] mask;
  logic [1:0] digit_select;
  logic       en;
  logic       scan_tick;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(
    .CLK_FREQ    (CLK_FREQ),
    .SCAN_FREQ   (SCAN_FREQ),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_run        (run),
    .i_digitMask  (mask),
    .o_digitSelect(digit_select),
    .o_en         (en),
    .o_scanTick   (scan_tick)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected digit indices at successive scan ticks.
  logic [1:0] exp_q[$];
  logic [1:0] exp_head;

  // Reference model
  bit         m_active;
  int         m_sel;
  int         m_pos;
  bit         m_tick;
  logic [1:0] exp_sel;
  logic       exp_en;
  logic       exp_tick;

  function automatic int ref_first(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int ref_next(input int d, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(d + k) % 4]) return (d + k) % 4;
    return d;
  endfunction

  task automatic model_outputs();
    exp_sel  = 2'(m_sel);
    exp_en   = !(m_active && (m_pos >= BLANK));
    exp_tick = m_tick;
  endtask

  task automatic model_reset();
    m_active = 0;
    m_sel    = 0;
    m_pos    = 0;
    m_tick   = 0;
    model_outputs();
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_tick = 0;
    if (!run || mask == 4'b0000) begin
      m_active = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_sel    = ref_first(mask);
      m_pos    = 0;
      m_tick   = 1;
    end else if (m_pos == DIV - 1) begin
      m_sel  = ref_next(m_sel, mask);
      m_pos  = 0;
      m_tick = 1;
    end else begin
      m_pos++;
    end
    model_outputs();
  endtask

  // Driver: advance one clock, update the model, then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; mask = 4'b0000;
    model_reset();
    step(); step();
    checks++;
    if ({digit_select, en, scan_tick} !== {2'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_values sel/en/tick got %0d/%0b/%0b want 0/1/0", digit_select, en, scan_tick);
    end
    rst_n = 1'b1;
    step(); step();
    checks++;
    if ({digit_select, en, scan_tick} !== {2'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL idle_after_release sel/en/tick got %0d/%0b/%0b want 0/1/0", digit_select, en, scan_tick);
    end
  endtask

  task automatic test_full_scan();
    int ticks = 0;
    int last  = 0;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    run = 1'b1; mask = 4'b1111;
    for (int c = 1; c <= 41; c++) begin
      step();
      checks++;
      if ({digit_select, en, scan_tick} !== {exp_sel, exp_en, exp_tick}) begin
        failures++;
        $display("FAIL full_scan c%0d sel/en/tick got %0d/%0b/%0b want %0d/%0b/%0b", c, digit_select, en, scan_tick, exp_sel, exp_en, exp_tick);
      end
      if (exp_tick && exp_q.size() > 0) begin
        exp_head = exp_q.pop_front();
        checks++;
        if (digit_select !== exp_head) begin
          failures++;
          $display("FAIL full_scan_seq sel got %0d want %0d", digit_select, exp_head);
        end
        if (ticks > 0) begin
          checks++;
          if (c - last != DIV) begin
            failures++;
            $display("FAIL full_scan_spacing got %0d want %0d", c - last, DIV);
          end
        end
        ticks++;
        last = c;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_scan_count left %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_alt_mask();
    run = 1'b0; step();
    exp_q = '{2'd0, 2'd2, 2'd0, 2'd2};
    run = 1'b1; mask = 4'b0101;
    for (int c = 1; c <= 31; c++) begin
      step();
      checks++;
      if ({digit_select, en, scan_tick} !== {exp_sel, exp_en, exp_tick} || digit_select[0] !== 1'b0) begin
        failures++;
        $display("FAIL alt_mask c%0d sel/en/tick got %0d/%0b/%0b want %0d/%0b/%0b", c, digit_select, en, scan_tick, exp_sel, exp_en, exp_tick);
      end
      if (exp_tick && exp_q.size() > 0) begin
        exp_head = exp_q.pop_front();
        checks++;
        if (digit_select !== exp_head) begin
          failures++;
          $display("FAIL alt_mask_seq sel got %0d want %0d", digit_select, exp_head);
        end
      end
    end
  endtask

  task automatic test_single_digit();
    int ticks = 0;
    int blanks = 0;
    run = 1'b0; step();
    run = 1'b1; mask = 4'b1000;
    for (int c = 1; c <= 31; c++) begin
      step();
      checks++;
      if ({digit_select, en, scan_tick} !== {2'd3, exp_en, exp_tick}) begin
        failures++;
        $display("FAIL single_digit c%0d sel/en/tick got %0d/%0b/%0b want 3/%0b/%0b", c, digit_select, en, scan_tick, exp_en, exp_tick);
      end
      if (scan_tick === 1'b1) ticks++;
      if (en === 1'b1) blanks++;
    end
    checks++;
    if (ticks != 4 || blanks != 7) begin
      failures++;
      $display("FAIL single_digit_counts ticks/blanks got %0d/%0d want 4/7", ticks, blanks);
    end
  endtask

  task automatic test_run_drop();
    run = 1'b0; step();
    run = 1'b1; mask = 4'b1111;
    repeat (15) step();
    run = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({digit_select, en, scan_tick} !== {2'd1, 1'b1, 1'b0} || {digit_select, en, scan_tick} !== {exp_sel, exp_en, exp_tick}) begin
        failures++;
        $display("FAIL run_drop c%0d sel/en/tick got %0d/%0b/%0b want 1/1/0", c, digit_select, en, scan_tick);
      end
    end
    run = 1'b1; mask = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({digit_select, en, scan_tick} !== {2'd1, (c < 2) ? 1'b1 : 1'b0, (c == 0) ? 1'b1 : 1'b0}) begin
        failures++;
        $display("FAIL run_restart c%0d sel/en/tick got %0d/%0b/%0b want %0d/%0b/%0b", c, digit_select, en, scan_tick, exp_sel, exp_en, exp_tick);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (3) step();
    checks++;
    if (en !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_precond en got %0b want 0", en);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({digit_select, en, scan_tick} !== {2'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_immediate sel/en/tick got %0d/%0b/%0b want 0/1/0", digit_select, en, scan_tick);
    end
    @(negedge clk);
    step(); step();
    rst_n = 1'b1; run = 1'b1; mask = 4'b1111;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int c = 1; c <= 41; c++) begin
      step();
      checks++;
      if ({digit_select, en, scan_tick} !== {exp_sel, exp_en, exp_tick}) begin
        failures++;
        $display("FAIL async_resume c%0d sel/en/tick got %0d/%0b/%0b want %0d/%0b/%0b", c, digit_select, en, scan_tick, exp_sel, exp_en, exp_tick);
      end
      if (exp_tick && exp_q.size() > 0) begin
        exp_head = exp_q.pop_front();
        checks++;
        if (digit_select !== exp_head) begin
          failures++;
          $display("FAIL async_resume_seq sel got %0d want %0d", digit_select, exp_head);
        end
      end
    end
  endtask

  task automatic test_mask_zero();
    bit found = 0;
    run = 1'b1; mask = 4'b1111;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      if (exp_sel == 2'd2 && exp_en == 1'b0) found = 1;
    end
    checks++;
    if (!found || digit_select !== 2'd2 || en !== 1'b0) begin
      failures++;
      $display("FAIL mask_zero_precond sel/en got %0d/%0b want 2/0 (found=%0b)", digit_select, en, found);
    end
    mask = 4'b0000;
    step();
    checks++;
    if ({digit_select, en, scan_tick} !== {2'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mask_zero_idle sel/en/tick got %0d/%0b/%0b want 2/1/0", digit_select, en, scan_tick);
    end
    mask = 4'b0011;
    for (int c = 1; c <= 11; c++) begin
      step();
      checks++;
      if ({digit_select, en, scan_tick} !== {exp_sel, exp_en, exp_tick}) begin
        failures++;
        $display("FAIL mask_restore c%0d sel/en/tick got %0d/%0b/%0b want %0d/%0b/%0b", c, digit_select, en, scan_tick, exp_sel, exp_en, exp_tick);
      end
    end
    checks++;
    if ({digit_select, scan_tick} !== {2'd1, 1'b1}) begin
      failures++;
      $display("FAIL mask_restore_second sel/tick got %0d/%0b want 1/1", digit_select, scan_tick);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      run   = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 11) == 0) mask = 4'($urandom_range(0, 15));
      step();
      checks++;
      if ({digit_select, en, scan_tick} !== {exp_sel, exp_en, exp_tick}) begin
        failures++;
        $display("FAIL random c%0d sel/en/tick got %0d/%0b/%0b want %0d/%0b/%0b", c, digit_select, en, scan_tick, exp_sel, exp_en, exp_tick);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mask = 4'b0000;
    model_reset();
    test_reset();
    test_full_scan();
    test_alt_mask();
    test_single_digit();
    test_run_drop();
    test_async_reset();
    test_mask_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Time-multiplexing controller for the 4-digit FND. It sits directly upstream of the BCD adder/FND decode stage. Its o_digitSelect drives that stage's i_digitSelect and its o_en drives that stage's i_en. It divides the system clock to a per-digit scan rate, steps through enabled digits and inserts a blanking window at every digit change to suppress ghosting.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
SCAN_FREQ, 1_000, digit-advance rate in Hz; DIV = CLK_FREQ/SCAN_FREQ clocks per digit (DIV >= 2)
BLANK_CYCLES, 1_000, clocks of blanking after each digit change; 0 = no blanking; must be < DIV

Ports:
i_clk  input  1  system clock, rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_run  input  1  1 = scanning, 0 = display off (IDLE)
i_digitMask  input  4  bit n = 1 means digit n is shown; 0 bits are skipped (leading-zero suppression)
o_digitSelect  output  2  current digit index, to downstream i_digitSelect
o_en  output  1  to downstream i_en; 0 = digit displayed, 1 = all digits blanked
o_scanTick  output  1  one-clock pulse in the cycle o_digitSelect changes

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low on i_reset_n. All state is cleared immediately on assertion.
- Reset values: o_digitSelect=0, o_en=1, o_scanTick=0, prescaler=0, blank counter=0, state=IDLE.
- States:
  - IDLE: o_en=1, prescaler held at 0, o_digitSelect held.
  - BLANK: o_en=1, blank counter counting down.
  - SHOW: o_en=0.
- Prescaler: counts 0..DIV-1 in BLANK/SHOW and wraps to 0. tick = (count==DIV-1).
- Next-digit function nxt(d): the first index with a mask bit set, searching d+1, d+2, d+3, d in that order, mod 4 (3 wraps to 0). If only d is set, nxt(d)=d.
- IDLE -> BLANK: when i_run=1 and i_digitMask!=0.
  - Next cycle: o_digitSelect = first set mask bit searching 0,1,2,3.
  - o_scanTick=1 for that cycle; prescaler=0; blank counter=BLANK_CYCLES.
  - If BLANK_CYCLES=0, go directly to SHOW.
- BLANK: blank counter decrements each clock. After exactly BLANK_CYCLES cycles with o_en=1, enter SHOW.
- SHOW on tick:
  - Next cycle: o_digitSelect=nxt(o_digitSelect), o_scanTick=1, enter BLANK (or stay in SHOW if BLANK_CYCLES=0).
  - o_scanTick pulses even when nxt returns the same digit.
- Timing: digit period is exactly DIV clocks. In each period, o_en=1 for the first BLANK_CYCLES clocks, then o_en=0 for DIV-BLANK_CYCLES clocks.
- Any state -> IDLE: when i_run=0 or i_digitMask==0, sampled at the clock edge. o_en=1 from the next cycle. No o_scanTick.
- Mask change during scanning: takes effect only at the next tick, except all-zero mask, which forces IDLE. A digit that becomes masked while shown stays shown until the tick.
- Reset mid-scan: outputs return to reset values asynchronously. After release, the block restarts from IDLE.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
All cases use CLK_FREQ=100, SCAN_FREQ=10 (DIV=10), BLANK_CYCLES=2.
1. Reset, then i_run=1, mask=4'b1111 -> o_digitSelect sequence 0,1,2,3,0 at 10-clock spacing. o_scanTick pulses each change. o_en=1 for 2 clocks then 0 for 8 clocks per digit.
2. mask=4'b0101, running -> o_digitSelect alternates 0,2,0,2 every 10 clocks. Digits 1 and 3 never appear.
3. mask=4'b1000 -> o_digitSelect=3 constant. o_scanTick still pulses every 10 clocks, with a 2-clock o_en=1 blank each time.
4. While scanning, drop i_run to 0 -> o_en=1 the next cycle and o_digitSelect held. Reassert with mask=4'b0110 -> o_digitSelect=1 with o_scanTick=1, then 2 blank clocks.
5. Assert i_reset_n=0 asynchronously mid-SHOW (between clock edges) -> o_en=1 and o_digitSelect=0 immediately, before the next edge. After release with i_run=1, scanning resumes per scenario 1.
6. Change mask from 4'b1111 to 4'b0000 while digit 2 is shown -> IDLE next cycle with o_en=1. Restoring mask=4'b0011 -> o_digitSelect=0, then 1 after 10 clocks.
